// File: rtl/mips_exc_pkg.sv
// mips_exc_pkg: cause codes and sequencer state shared by the exception logic.
package mips_exc_pkg;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] ERET_TAG = 5'h1F;
  typedef enum logic {S_IDLE, S_SETTLE} state_e;
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: picks interrupt > exception > eret and forms cause, victim PC and target.
module exc_prio_enc
  import mips_exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        int_i,
  input  logic        valid_i,
  input  logic        exc_i,
  input  logic [4:0]  code_i,
  input  logic        eret_i,
  input  logic [31:0] pc_i,
  input  logic        bd_i,
  input  logic [31:0] epc_i,
  output logic        event_o,
  output logic        trap_o,
  output logic        eret_o,
  output logic [4:0]  code_o,
  output logic [4:0]  tag_o,
  output logic [31:0] cp0_pc_o,
  output logic [31:0] target_o,
  output logic        bd_o
);
  always_comb begin
    trap_o   = int_i | (valid_i & exc_i);
    eret_o   = ~trap_o & valid_i & eret_i;
    event_o  = trap_o | eret_o;
    code_o   = int_i ? EXC_INT : trap_o ? code_i : 5'd0;
    tag_o    = trap_o ? code_o : ERET_TAG;
    bd_o     = trap_o & bd_i;
    // a delay-slot victim restarts at its branch so the branch re-executes
    cp0_pc_o = !trap_o ? 32'd0 : bd_i ? pc_i - 32'd4 : pc_i;
    target_o = trap_o ? HANDLER_ADDR : epc_i;
  end
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: M-stage exception/interrupt sequencer; flushes, redirects and pulses CP0,
// then ignores events for a settle window while the pipeline refills.
module exc_ctrl
  import mips_exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          SETTLE_CYC   = 3,
  parameter int          CNT_W        = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] M_PC,
  input  logic        M_BD,
  input  logic        M_Valid,
  input  logic        M_ExcValid,
  input  logic [4:0]  M_ExcCode,
  input  logic        M_Eret,
  input  logic        IntReq,
  input  logic [31:0] EPC_In,
  input  logic        Hold,
  output logic        EXLSet,
  output logic        EXLClr,
  output logic [31:0] CP0_PC,
  output logic [4:0]  ExcCode,
  output logic        BDOut,
  output logic        Flush,
  output logic        PC_Redirect,
  output logic [31:0] PC_Target,
  output logic        Busy,
  output logic [4:0]  LastExcCode
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         last_q, last_d;
  logic               ev, trap, eret, bd, go;
  logic [4:0]         code, tag;
  logic [31:0]        cp0_pc, target;

  exc_prio_enc #(.HANDLER_ADDR(HANDLER_ADDR)) u_prio (
    .int_i   (IntReq),
    .valid_i (M_Valid),
    .exc_i   (M_ExcValid),
    .code_i  (M_ExcCode),
    .eret_i  (M_Eret),
    .pc_i    (M_PC),
    .bd_i    (M_BD),
    .epc_i   (EPC_In),
    .event_o (ev),
    .trap_o  (trap),
    .eret_o  (eret),
    .code_o  (code),
    .tag_o   (tag),
    .cp0_pc_o(cp0_pc),
    .target_o(target),
    .bd_o    (bd)
  );

  // Reset gates the decision so an event seen in the Reset cycle never pulses
  always_comb begin
    go          = (state_q == S_IDLE) & ~Hold & ~Reset & ev;
    EXLSet      = go & trap;
    EXLClr      = go & eret;
    Flush       = go;
    PC_Redirect = go;
    CP0_PC      = go ? cp0_pc : 32'd0;
    ExcCode     = go ? code : 5'd0;
    BDOut       = go & bd;
    PC_Target   = go ? target : 32'd0;
    Busy        = state_q == S_SETTLE;
    LastExcCode = last_q;
    state_d     = go ? S_SETTLE : (state_q == S_SETTLE && cnt_q == '0) ? S_IDLE : state_q;
    cnt_d       = go ? CNT_W'(SETTLE_CYC - 1) : cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
    last_d      = go ? tag : last_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: vector table, corner sequences and random traffic against a cycle-count model.
module tb_exc_ctrl;
  import mips_exc_pkg::*;
  localparam int SETTLE = 3;

  logic        Clk, Reset;
  logic [31:0] M_PC, EPC_In;
  logic        M_BD, M_Valid, M_ExcValid, M_Eret, IntReq, Hold;
  logic [4:0]  M_ExcCode;
  logic        EXLSet, EXLClr, BDOut, Flush, PC_Redirect, Busy;
  logic [31:0] CP0_PC, PC_Target;
  logic [4:0]  ExcCode, LastExcCode;

  exc_ctrl dut (
    .Clk(Clk), .Reset(Reset), .M_PC(M_PC), .M_BD(M_BD), .M_Valid(M_Valid),
    .M_ExcValid(M_ExcValid), .M_ExcCode(M_ExcCode), .M_Eret(M_Eret), .IntReq(IntReq),
    .EPC_In(EPC_In), .Hold(Hold), .EXLSet(EXLSet), .EXLClr(EXLClr), .CP0_PC(CP0_PC),
    .ExcCode(ExcCode), .BDOut(BDOut), .Flush(Flush), .PC_Redirect(PC_Redirect),
    .PC_Target(PC_Target), .Busy(Busy), .LastExcCode(LastExcCode)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0, checks = 0;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // model: blocked while fewer than SETTLE+1 cycles have elapsed since the last take
  int          cyc = 0, take_cyc = -100;
  logic [4:0]  m_last = 5'd0, m_next_last;
  logic        m_go, m_rst;
  logic [79:0] exp_v;
  wire  [79:0] act_v = {EXLSet, EXLClr, CP0_PC, ExcCode, BDOut, Flush, PC_Redirect,
                        PC_Target, Busy, LastExcCode};

  task automatic model_eval();
    logic idle, ti, te, tr, trap;
    logic [31:0] vpc;
    idle = (cyc - take_cyc) > SETTLE;
    ti = IntReq;
    te = M_Valid && M_ExcValid;
    tr = M_Valid && M_Eret;
    trap = ti || te;
    m_rst = Reset;
    m_go = !Reset && idle && !Hold && (trap || tr);
    vpc = M_BD ? M_PC - 32'd4 : M_PC;
    m_next_last = ti ? 5'd0 : te ? M_ExcCode : 5'h1F;
    exp_v = {m_go && trap, m_go && !trap, (m_go && trap) ? vpc : 32'd0,
             (m_go && te && !ti) ? M_ExcCode : 5'd0, m_go && trap && M_BD, m_go, m_go,
             m_go ? (trap ? 32'h0000_4180 : EPC_In) : 32'd0, !idle, m_last};
  endtask

  task automatic chk_cycle();
    @(negedge Clk);
    model_eval();
    check("model", act_v, exp_v);
  endtask

  task automatic adv();
    @(posedge Clk);
    if (m_rst) begin
      take_cyc = -100;
      m_last = 5'd0;
    end else if (m_go) begin
      take_cyc = cyc;
      m_last = m_next_last;
    end
    cyc++;
    #1;
  endtask

  task automatic clr();
    {IntReq, M_Valid, M_ExcValid, M_Eret, Hold, M_BD, Reset} = '0;
    M_ExcCode = 5'd0;
    M_PC = 32'h0000_3000;
    EPC_In = 32'd0;
  endtask

  typedef struct {
    logic irq, valid, exc; logic [4:0] code; logic eret; logic [31:0] pc; logic bd;
    logic [31:0] epc; logic set, clr; logic [31:0] cp0pc; logic [4:0] xcode; logic bdo;
    logic [31:0] tgt; logic [4:0] last;
  } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{1'b1,1'b0,1'b0,5'd0,1'b0,32'h3010,1'b0,32'h0,  1'b1,1'b0,32'h3010,5'd0,1'b0,32'h4180,5'd0};
    vt[1] = '{1'b0,1'b1,1'b1,5'd4,1'b0,32'h3024,1'b1,32'h0,  1'b1,1'b0,32'h3020,5'd4,1'b1,32'h4180,5'd4};
    vt[2] = '{1'b0,1'b1,1'b0,5'd0,1'b1,32'h3000,1'b0,32'h3030,1'b0,1'b1,32'h0,5'd0,1'b0,32'h3030,5'h1F};
    vt[3] = '{1'b1,1'b1,1'b1,5'd10,1'b0,32'h3040,1'b0,32'h0, 1'b1,1'b0,32'h3040,5'd0,1'b0,32'h4180,5'd0};
    vt[4] = '{1'b1,1'b1,1'b0,5'd0,1'b1,32'h3050,1'b1,32'h3030,1'b1,1'b0,32'h304C,5'd0,1'b1,32'h4180,5'd0};
    vt[5] = '{1'b0,1'b0,1'b1,5'd12,1'b1,32'h3060,1'b0,32'h5555,1'b0,1'b0,32'h0,5'd0,1'b0,32'h0,5'd0};
    vt[6] = '{1'b0,1'b1,1'b1,5'd12,1'b0,32'h0,1'b1,32'h0,    1'b1,1'b0,32'hFFFF_FFFC,5'd12,1'b1,32'h4180,5'd12};
    vt[7] = '{1'b0,1'b1,1'b1,5'd5,1'b1,32'h3070,1'b0,32'h3030,1'b1,1'b0,32'h3070,5'd5,1'b0,32'h4180,5'd5};

    clr();
    Reset = 1'b1;
    #1;
    chk_cycle(); adv();
    chk_cycle(); adv();
    Reset = 1'b0;
    chk_cycle();
    check("reset_state", act_v, 80'd0);
    adv();

    foreach (vt[i]) begin
      logic tk;
      IntReq = vt[i].irq; M_Valid = vt[i].valid; M_ExcValid = vt[i].exc;
      M_ExcCode = vt[i].code; M_Eret = vt[i].eret; M_PC = vt[i].pc; M_BD = vt[i].bd;
      EPC_In = vt[i].epc;
      tk = vt[i].set | vt[i].clr;
      chk_cycle();
      check($sformatf("vec%0d", i),
            {EXLSet, EXLClr, CP0_PC, ExcCode, BDOut, Flush, PC_Redirect, PC_Target},
            {vt[i].set, vt[i].clr, vt[i].cp0pc, vt[i].xcode, vt[i].bdo, tk, tk, vt[i].tgt});
      adv();
      clr();
      for (int k = 0; k < (tk ? SETTLE : 0); k++) begin
        chk_cycle();
        check($sformatf("vec%0d_busy", i), {79'd0, Busy}, 80'd1);
        adv();
      end
      chk_cycle();
      check($sformatf("vec%0d_last", i), {74'd0, Busy, LastExcCode}, {75'd0, vt[i].last});
      adv();
    end

    // interrupt beats exception, then held IntReq retakes in the first idle cycle
    IntReq = 1'b1; M_Valid = 1'b1; M_ExcValid = 1'b1; M_ExcCode = EXC_RI; M_PC = 32'h3080;
    for (int k = 0; k <= SETTLE + 1; k++) begin
      chk_cycle();
      check($sformatf("irq_held_c%0d", k), {78'd0, EXLSet, Busy},
            {78'd0, (k == 0 || k == SETTLE + 1), (k != 0 && k != SETTLE + 1)});
      adv();
      M_ExcValid = 1'b0;
    end
    clr();
    for (int k = 0; k < SETTLE; k++) begin chk_cycle(); adv(); end

    // Hold defers; release takes the same cycle
    IntReq = 1'b1; Hold = 1'b1; M_PC = 32'h3090;
    for (int k = 0; k < 4; k++) begin
      chk_cycle();
      check($sformatf("hold_c%0d", k), {77'd0, Flush, EXLSet, Busy}, 80'd0);
      adv();
    end
    Hold = 1'b0;
    chk_cycle();
    check("hold_release", {47'd0, EXLSet, CP0_PC}, {47'd0, 1'b1, 32'h3090});
    adv();
    clr();
    for (int k = 0; k < SETTLE; k++) begin chk_cycle(); adv(); end

    // exception during settle ignored; Reset mid-settle clears everything
    M_Valid = 1'b1; M_ExcValid = 1'b1; M_ExcCode = EXC_OV; M_PC = 32'h30A0;
    chk_cycle();
    check("settle_take", {74'd0, EXLSet, ExcCode}, {74'd0, 1'b1, EXC_OV});
    adv();
    M_ExcCode = EXC_ADEL;
    chk_cycle();
    check("settle_ignore", {78'd0, Flush, Busy}, {78'd0, 1'b0, 1'b1});
    adv();
    Reset = 1'b1; IntReq = 1'b1;
    chk_cycle();
    check("reset_cycle_nopulse", {78'd0, EXLSet, Flush}, 80'd0);
    adv();
    clr();
    chk_cycle();
    check("after_reset", act_v, 80'd0);
    adv();

    for (int n = 0; n < 600; n++) begin
      IntReq     = ($urandom % 6) == 0;
      M_Valid    = ($urandom % 4) != 0;
      M_ExcValid = ($urandom % 5) == 0;
      M_ExcCode  = 5'($urandom);
      M_Eret     = ($urandom % 5) == 0;
      Hold       = ($urandom % 4) == 0;
      Reset      = ($urandom % 60) == 0;
      M_BD       = 1'($urandom);
      M_PC       = ($urandom % 8) == 0 ? 32'($urandom_range(0, 8)) : ($urandom & 32'hFFFF_FFFC);
      EPC_In     = $urandom;
      chk_cycle();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
